// File: rtl/cpu_mem_arb_pkg.sv
// cpu_mem_arb_pkg: types and default sizes shared by the CPU memory-port arbiter.
//   arb_state_t : arbiter sequencing (IDLE -> REQ -> RESP -> IDLE)
//   owner_t     : which requester owns the transaction in flight
package cpu_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one CPU memory port between the instruction-fetch
// and data-access requesters, one transaction at a time.
//   sys_clk, sys_reset_n      : clock, asynchronous active-low reset
//   inst_req_* / inst_resp_*  : fetch request (addr) and read response
//   data_req_* / data_resp_*  : load/store request (addr, wen, wstrb, wdata) and load response
//   mem_req_* / mem_resp_*    : memory request channel (registered fields) and read response
// Data wins a simultaneous request unless the fetch has been bypassed
// STARVE_LIMIT times in a row. Stores complete on memory acceptance.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ARB_ADDR_W,
    parameter int unsigned DATA_W       = ARB_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                sys_clk,
    input  logic                sys_reset_n,
    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_resp_valid,
    input  logic                inst_resp_ready,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req_valid,
    output logic                data_req_ready,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_wen,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_resp_valid,
    input  logic                data_resp_ready,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    owner_t           owner, owner_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_nxt;

    logic inst_win, data_win, inst_hs, data_hs;
    logic in_resp, owner_resp_ready;

    always_comb begin
        inst_win = inst_req_valid && (!data_req_valid || (starve_cnt == CNT_MAX));
        data_win = data_req_valid && !inst_win;
        // Reset is folded in so ready stays low while reset is held, even
        // though the state register already reads IDLE.
        inst_hs  = sys_reset_n && (state == IDLE) && inst_win;
        data_hs  = sys_reset_n && (state == IDLE) && data_win;
        owner_resp_ready = (owner == OWN_DATA) ? data_resp_ready : inst_resp_ready;
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (!inst_req_valid)
                    starve_nxt = '0;
                if (inst_hs) begin
                    state_nxt  = REQ;
                    owner_nxt  = OWN_INST;
                    starve_nxt = '0;
                end else if (data_hs) begin
                    state_nxt = REQ;
                    owner_nxt = OWN_DATA;
                    if (inst_req_valid && (starve_cnt != CNT_MAX))
                        starve_nxt = starve_cnt + 1'b1;
                end
            end
            REQ: begin
                if (mem_req_ready)
                    state_nxt = mem_wen ? IDLE : RESP;
            end
            RESP: begin
                if (mem_resp_valid && owner_resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wstrb  <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            if (inst_hs) begin
                mem_addr  <= inst_addr;
                mem_wen   <= 1'b0;
                mem_wstrb <= '0;
                mem_wdata <= '0;
            end else if (data_hs) begin
                mem_addr  <= data_addr;
                mem_wen   <= data_wen;
                mem_wstrb <= data_wstrb;
                mem_wdata <= data_wdata;
            end
        end
    end

    always_comb begin
        in_resp         = (state == RESP);
        inst_req_ready  = inst_hs;
        data_req_ready  = data_hs;
        mem_req_valid   = (state == REQ);
        mem_resp_ready  = in_resp && owner_resp_ready;
        inst_resp_valid = in_resp && (owner == OWN_INST) && mem_resp_valid;
        data_resp_valid = in_resp && (owner == OWN_DATA) && mem_resp_valid;
        inst_rdata      = (in_resp && (owner == OWN_INST)) ? mem_rdata : '0;
        data_rdata      = (in_resp && (owner == OWN_DATA)) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: vectors, directed sequences and a randomized run
// checked against a transaction-level model of the arbiter.
module tb_cpu_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned LIMIT = 4;

    logic          sys_clk = 1'b0;
    logic          sys_reset_n;
    logic          inst_req_valid, inst_req_ready, inst_resp_valid, inst_resp_ready;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          data_req_valid, data_req_ready, data_wen, data_resp_valid, data_resp_ready;
    logic [AW-1:0] data_addr;
    logic [SW-1:0] data_wstrb;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
        .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready), .inst_rdata(inst_rdata),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_addr(data_addr),
        .data_wen(data_wen), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic iv;
        logic dv;
        logic exp_ir;
        logic exp_dr;
    } arb_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
        logic          is_data;
    } txn_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        inst_req_valid = 0; inst_addr = '0; inst_resp_ready = 0;
        data_req_valid = 0; data_addr = '0; data_wen = 0; data_wstrb = '0; data_wdata = '0;
        data_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_reset_n = 0;
        tick();
        tick();
        sys_reset_n = 1;
    endtask

    // Inst and data both valid with data stores accepted at once: count data
    // grants before the fetch gets through, then finish the fetch.
    task automatic starve_round(input string tag);
        int n_data = 0;
        bit got_inst = 0;
        inst_req_valid = 1; inst_addr = 32'h40; inst_resp_ready = 1;
        data_req_valid = 1; data_addr = 32'h80; data_wen = 1; data_wstrb = 4'hF; data_wdata = 32'h1234;
        mem_req_ready = 1;
        for (int c = 0; c < 40 && !got_inst; c++) begin
            settle();
            if (data_req_ready === 1'b1) n_data++;
            if (inst_req_ready === 1'b1) got_inst = 1;
            tick();
        end
        chk({tag, "_inst_granted"}, 64'(got_inst), 64'd1);
        chk({tag, "_data_grants"}, 64'(n_data), 64'(LIMIT));
        inst_req_valid = 0;
        settle();
        chk({tag, "_inst_mem_addr"}, 64'(mem_addr), 64'h40);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'hCAFE_0001;
        settle();
        chk({tag, "_inst_resp"}, 64'(inst_rdata), 64'hCAFE_0001);
        tick();
        mem_resp_valid = 0;
    endtask

    arb_vec_t vecs[4];

    // Transaction-level reference model state.
    bit   busy;
    bit   waiting_resp;
    int   bypassed;
    txn_t cur;
    bit   inst_taken, data_taken, resp_taken;

    initial begin
        sys_reset_n = 0;
        clear_inputs();
        vecs[0] = '{iv: 0, dv: 0, exp_ir: 0, exp_dr: 0};
        vecs[1] = '{iv: 1, dv: 0, exp_ir: 1, exp_dr: 0};
        vecs[2] = '{iv: 0, dv: 1, exp_ir: 0, exp_dr: 1};
        vecs[3] = '{iv: 1, dv: 1, exp_ir: 0, exp_dr: 1};

        // Reset values
        settle();
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
        chk("rst_inst_req_ready", 64'(inst_req_ready), 64'd0);
        do_reset();

        // Combinational arbitration in IDLE, no clock edge between vectors
        for (int i = 0; i < 4; i++) begin
            inst_req_valid = vecs[i].iv;
            data_req_valid = vecs[i].dv;
            #1;
            chk($sformatf("vec%0d_inst_ready", i), 64'(inst_req_ready), 64'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_data_ready", i), 64'(data_req_ready), 64'(vecs[i].exp_dr));
        end
        inst_req_valid = 0; data_req_valid = 0;
        tick();

        // Inst only
        inst_req_valid = 1; inst_addr = 32'h10; mem_req_ready = 1; inst_resp_ready = 1;
        settle();
        chk("io_ready", 64'(inst_req_ready), 64'd1);
        chk("io_no_same_cycle_req", 64'(mem_req_valid), 64'd0);
        tick();
        inst_req_valid = 0;
        settle();
        chk("io_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("io_mem_addr", 64'(mem_addr), 64'h10);
        chk("io_mem_wen", 64'(mem_wen), 64'd0);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h13;
        settle();
        chk("io_resp_valid", 64'(inst_resp_valid), 64'd1);
        chk("io_rdata", 64'(inst_rdata), 64'h13);
        chk("io_data_resp_valid", 64'(data_resp_valid), 64'd0);
        tick();
        mem_resp_valid = 0;
        settle();
        chk("io_done_idle", 64'(mem_req_valid | mem_resp_ready), 64'd0);

        // Simultaneous: data load first, inst after the load response
        inst_req_valid = 1; inst_addr = 32'h20;
        data_req_valid = 1; data_addr = 32'h100; data_wen = 0; data_resp_ready = 1;
        settle();
        chk("sim_data_first", 64'({inst_req_ready, data_req_ready}), 64'b01);
        tick();
        data_req_valid = 0;
        settle();
        chk("sim_mem_addr_data", 64'(mem_addr), 64'h100);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'hABCD;
        settle();
        chk("sim_data_rdata", 64'(data_rdata), 64'hABCD);
        chk("sim_no_regrant", 64'(inst_req_ready), 64'd0);
        tick();
        mem_resp_valid = 0;
        settle();
        chk("sim_inst_next", 64'(inst_req_ready), 64'd1);
        tick();
        inst_req_valid = 0;
        settle();
        chk("sim_mem_addr_inst", 64'(mem_addr), 64'h20);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h77;
        settle();
        chk("sim_inst_resp", 64'({inst_resp_valid, data_resp_valid}), 64'b10);
        tick();
        mem_resp_valid = 0;

        // Store with memory acceptance delayed 3 cycles
        mem_req_ready = 0;
        data_req_valid = 1; data_wen = 1; data_addr = 32'h0C; data_wdata = 32'h0; data_wstrb = 4'hF;
        settle();
        chk("st_grant", 64'(data_req_ready), 64'd1);
        tick();
        data_req_valid = 0; data_wen = 0; data_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("st_hold%0d", i),
                64'({mem_req_valid, mem_wen, mem_wstrb, mem_addr[7:0], mem_wdata[7:0]}),
                64'({1'b1, 1'b1, 4'hF, 8'h0C, 8'h00}));
            tick();
        end
        mem_req_ready = 1;
        settle();
        chk("st_accept_valid", 64'(mem_req_valid), 64'd1);
        tick();
        mem_req_ready = 0; mem_resp_valid = 1;
        settle();
        chk("st_idle_after", 64'({mem_req_valid, mem_resp_ready, data_resp_valid}), 64'd0);
        mem_resp_valid = 0;
        tick();

        // Starvation, twice to show the counter was cleared by the inst grant
        starve_round("starve1");
        starve_round("starve2");
        data_req_valid = 0; data_wen = 0;
        tick();

        // Response back-pressure
        mem_req_ready = 1; data_resp_ready = 0; inst_resp_ready = 0;
        data_req_valid = 1; data_wen = 0; data_addr = 32'h200;
        settle();
        chk("bp_grant", 64'(data_req_ready), 64'd1);
        tick();
        data_req_valid = 0; inst_req_valid = 1; inst_addr = 32'h300;
        settle();
        chk("bp_mem_addr", 64'(mem_addr), 64'h200);
        tick();
        mem_resp_valid = 1; mem_rdata = 32'h5555;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("bp_stall%0d", i),
                64'({mem_resp_ready, data_resp_valid, inst_req_ready}), 64'b010);
            tick();
        end
        data_resp_ready = 1;
        settle();
        chk("bp_release", 64'({mem_resp_ready, data_rdata}), {31'd0, 1'b1, 32'h5555});
        tick();
        mem_resp_valid = 0;
        settle();
        chk("bp_inst_after", 64'(inst_req_ready), 64'd1);
        tick();
        inst_req_valid = 0;
        tick();
        mem_resp_valid = 1; inst_resp_ready = 1; mem_rdata = 32'h9999;
        settle();
        chk("rr_in_resp", 64'(inst_resp_valid), 64'd1);

        // Reset during RESP
        sys_reset_n = 0; inst_req_valid = 1;
        settle();
        chk("rr_outputs_low",
            64'({inst_req_ready, data_req_ready, inst_resp_valid, data_resp_valid, mem_req_valid, mem_resp_ready}),
            64'd0);
        chk("rr_mem_addr", 64'(mem_addr), 64'd0);
        tick();
        tick();
        sys_reset_n = 1;
        settle();
        chk("rr_no_stale_resp", 64'(inst_resp_valid), 64'd0);
        chk("rr_regrant", 64'(inst_req_ready), 64'd1);
        tick();
        inst_req_valid = 0;
        settle();
        chk("rr_mem_req", 64'({mem_req_valid, mem_addr}), {31'd0, 1'b1, 32'h300});
        tick();
        tick();
        mem_resp_valid = 0;

        // Randomized run against the transaction-level model
        do_reset();
        busy = 0; waiting_resp = 0; bypassed = 0;
        inst_taken = 0; data_taken = 0; resp_taken = 0;
        for (int c = 0; c < 3000; c++) begin
            bit win_i, win_d, acc, done;
            if (inst_taken) inst_req_valid = 0;
            if (data_taken) data_req_valid = 0;
            if (resp_taken) mem_resp_valid = 0;
            if (!inst_req_valid && ($urandom % 2 == 0)) begin
                inst_req_valid = 1; inst_addr = $urandom;
            end
            if (!data_req_valid && ($urandom % 2 == 0)) begin
                data_req_valid = 1; data_addr = $urandom; data_wen = 1'($urandom);
                data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            if (!mem_resp_valid && busy && waiting_resp && ($urandom % 3 == 0)) begin
                mem_resp_valid = 1; mem_rdata = $urandom;
            end
            mem_req_ready   = 1'($urandom);
            inst_resp_ready = 1'($urandom);
            data_resp_ready = 1'($urandom);
            settle();

            win_i = 0; win_d = 0; acc = 0; done = 0;
            if (!busy) begin
                win_i = inst_req_valid && (!data_req_valid || bypassed == LIMIT);
                win_d = data_req_valid && !win_i;
                chk("rnd_inst_ready", 64'(inst_req_ready), 64'(win_i));
                chk("rnd_data_ready", 64'(data_req_ready), 64'(win_d));
                chk("rnd_idle_quiet", 64'({mem_req_valid, mem_resp_ready, inst_resp_valid, data_resp_valid}), 64'd0);
            end else if (!waiting_resp) begin
                chk("rnd_req_readies", 64'({inst_req_ready, data_req_ready}), 64'd0);
                chk("rnd_req_valid", 64'(mem_req_valid), 64'd1);
                chk("rnd_req_fields", {mem_wen, mem_wstrb, mem_addr[26:0], mem_wdata[31:0]},
                    {cur.wen, cur.wstrb, cur.addr[26:0], cur.wdata});
                chk("rnd_req_addr_hi", 64'(mem_addr), 64'(cur.addr));
                acc = mem_req_ready;
            end else begin
                logic own_rdy;
                own_rdy = cur.is_data ? data_resp_ready : inst_resp_ready;
                chk("rnd_resp_readies", 64'({inst_req_ready, data_req_ready, mem_req_valid}), 64'd0);
                chk("rnd_mem_resp_ready", 64'(mem_resp_ready), 64'(own_rdy));
                chk("rnd_resp_valids", 64'({inst_resp_valid, data_resp_valid}),
                    cur.is_data ? 64'({1'b0, mem_resp_valid}) : 64'({mem_resp_valid, 1'b0}));
                if (mem_resp_valid)
                    chk("rnd_rdata", 64'(cur.is_data ? data_rdata : inst_rdata), 64'(mem_rdata));
                done = mem_resp_valid && own_rdy;
            end

            inst_taken = win_i; data_taken = win_d; resp_taken = done;
            if (!busy) begin
                if (win_i) begin
                    bypassed = 0;
                    cur = '{addr: inst_addr, wen: 0, wstrb: '0, wdata: '0, is_data: 0};
                    busy = 1; waiting_resp = 0;
                end else if (win_d) begin
                    bypassed = inst_req_valid ? ((bypassed < LIMIT) ? bypassed + 1 : LIMIT) : 0;
                    cur = '{addr: data_addr, wen: data_wen, wstrb: data_wstrb, wdata: data_wdata, is_data: 1};
                    busy = 1; waiting_resp = 0;
                end else begin
                    bypassed = 0;
                end
            end else if (acc) begin
                if (cur.wen) busy = 0;
                else waiting_resp = 1;
            end else if (done) begin
                busy = 0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the single CPU memory port (Address / MemWrite / Write_data / Read_data) between the turbo pipeline's instruction-fetch requester and its data-access requester.
- Accepts one request at a time, drives it onto the memory request channel and routes the read response back to the requester that owns it.
- Sits between the turbo custom_cpu front/back ends and the memory interface in cpu_test_top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width = DATA_W/8)
STARVE_LIMIT, 4, max consecutive data grants while a fetch is waiting

Ports:
sys_clk  in  1  clock
sys_reset_n  in  1  asynchronous active-low reset
inst_req_valid  in  1  fetch request valid
inst_req_ready  out  1  fetch request accepted
inst_addr  in  ADDR_W  fetch address
inst_resp_valid  out  1  fetch data valid
inst_resp_ready  in  1  fetch side can take data
inst_rdata  out  DATA_W  fetched instruction
data_req_valid  in  1  load/store request valid
data_req_ready  out  1  load/store request accepted
data_addr  in  ADDR_W  load/store address
data_wen  in  1  1 = store, 0 = load
data_wstrb  in  DATA_W/8  store byte strobes
data_wdata  in  DATA_W  store data
data_resp_valid  out  1  load data valid
data_resp_ready  in  1  data side can take load data
data_rdata  out  DATA_W  load data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  memory address (registered)
mem_wen  out  1  memory write enable (registered)
mem_wstrb  out  DATA_W/8  memory byte strobes (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_resp_valid  in  1  memory read data valid
mem_resp_ready  out  1  arbiter can take read data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, sys_reset_n low):
  - state=IDLE, owner=INST, starve_cnt=0.
  - All valid/ready outputs 0; mem_addr/mem_wen/mem_wstrb/mem_wdata 0.
  - An in-flight transaction is abandoned; no response is forwarded after reset.
- FSM IDLE -> REQ -> (RESP) -> IDLE.
- IDLE:
  - Arbitrate combinationally. Default: data wins when both requesters are valid.
  - Inst wins instead when starve_cnt == STARVE_LIMIT.
  - The winner's *_req_ready is 1 this cycle; the loser's is 0. Handshake = valid & ready.
  - On handshake, latch addr/wen/wstrb/wdata (wen=0, wstrb=0, wdata=0 for inst), record owner, go to REQ.
  - No valid requester: stay in IDLE.
- REQ:
  - mem_req_valid=1 with the latched fields held stable. Both upstream req_ready are 0.
  - On mem_req_ready: write goes to IDLE (store completes on acceptance; no response). Read goes to RESP.
  - Minimum latency: upstream handshake cycle N, mem_req_valid cycle N+1.
- RESP:
  - mem_resp_ready equals the owner's *_resp_ready. The owner's *_resp_valid equals mem_resp_valid.
  - The owner's rdata equals mem_rdata, combinational pass-through.
  - The non-owner's resp_valid is 0.
  - On mem_resp_valid & mem_resp_ready, go to IDLE. A new arbitration happens the following cycle, with no same-cycle re-grant.
- Starvation counter:
  - A data grant while inst_req_valid=1 increments starve_cnt, saturating at STARVE_LIMIT.
  - An inst grant, or inst_req_valid=0 in IDLE, clears it to 0.
- Requesters must hold valid and fields until the handshake. The arbiter never drops an accepted request.
- Back-pressure: a stalled mem_req_ready or *_resp_ready holds state indefinitely; outputs stay stable.

Decomposition:
- Shared package cpu_mem_arb_pkg holds:
  - state enum {IDLE, REQ, RESP}
  - owner encoding {OWN_INST=0, OWN_DATA=1}
  - default ADDR_W/DATA_W constants
- No sub-module. The grant/starvation logic is small enough to stay inline.

Test Plan:
- Inst only: inst_addr=0x0000_0010, mem_req_ready=1, mem_resp_valid with 0x0000_0013 two cycles later -> mem_req_valid on cycle N+1 with mem_addr=0x10, mem_wen=0; inst_resp_valid=1, inst_rdata=0x13; data_resp_valid stays 0.
- Simultaneous requests: inst 0x20 and data load 0x100 valid in the same cycle -> data granted first (mem_addr=0x100), inst granted in the IDLE after the load response, mem_addr=0x20.
- Store: data_wen=1, addr=0x0C, wdata=0, wstrb=0xF, mem_req_ready delayed 3 cycles -> fields stable for 3 cycles; IDLE the cycle after acceptance; no data_resp_valid.
- Starvation: inst held valid, data valid every cycle, STARVE_LIMIT=4 -> exactly 4 data grants, then an inst grant; starve_cnt returns to 0.
- Response back-pressure: load response with data_resp_ready=0 for 5 cycles -> mem_resp_ready=0 for those cycles; no new grant; handshake on the first cycle ready=1.
- Reset mid-RESP: sys_reset_n low during RESP -> immediately all valid/ready 0, state IDLE; after release the next request is arbitrated normally.
